// File: rtl/seg_scan_capture.sv
// Receive side of the multiplexed 7-segment scan bus: follows the digit scan order,
// decodes each digit back to BCD and publishes a coherent time/function frame per full scan.
module seg_scan_capture #(
    parameter int MAX_DWELL = 16
) (
    input  logic       CP,
    input  logic       CR,
    input  logic [7:0] seg,
    input  logic [7:0] codeout,
    output logic [7:0] hour,
    output logic [7:0] minute,
    output logic [7:0] second,
    output logic [1:0] NUM,
    output logic       frame_valid,
    output logic       locked,
    output logic       err
);

    localparam int DW = $clog2(MAX_DWELL + 1);

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        SCAN = 2'd1,
        GAP  = 2'd2,
        NUMS = 2'd3
    } state_t;

    // Returns {valid, digit}; the dp bit is a don't-care.
    function automatic logic [4:0] seg7_decode(input logic [7:0] pat);
        logic [4:0] r;
        casez (pat)
            8'b?0111111: r = 5'h10;
            8'b?0000110: r = 5'h11;
            8'b?1011011: r = 5'h12;
            8'b?1001111: r = 5'h13;
            8'b?1100110: r = 5'h14;
            8'b?1101101: r = 5'h15;
            8'b?1111101: r = 5'h16;
            8'b?0000111: r = 5'h17;
            8'b?1111111: r = 5'h18;
            8'b?1101111: r = 5'h19;
            default:     r = 5'h00;
        endcase
        return r;
    endfunction

    state_t        state_r, state_s;
    logic [2:0]    idx_r, idx_s;
    logic [6:0]    code_r, code_s;
    logic [DW-1:0] dwell_r, dwell_s;
    logic [23:0]   shadow_r, shadow_s;
    logic [7:0]    hour_r, hour_s, minute_r, minute_s, second_r, second_s;
    logic [1:0]    num_r, num_s;
    logic          frame_valid_r, frame_valid_s;
    logic          locked_r, locked_s;
    logic          err_r, err_s;

    logic [4:0]    dec_s;
    logic          dig_valid_s;
    logic [3:0]    dig_s;
    logic          relock_ok_s;
    logic [2:0]    idx_inc_s;
    logic [4:0]    nib_lsb_s;
    logic [7:0]    cur_seg_s, nxt_seg_s;
    logic          viol_s;

    assign dec_s       = seg7_decode(codeout);
    assign dig_valid_s = dec_s[4];
    assign dig_s       = dec_s[3:0];
    assign relock_ok_s = (seg == 8'h01) && dig_valid_s;
    assign idx_inc_s   = idx_r + 3'd1;
    assign nib_lsb_s   = {idx_inc_s, 2'b00};

    assign hour        = hour_r;
    assign minute      = minute_r;
    assign second      = second_r;
    assign NUM         = num_r;
    assign frame_valid = frame_valid_r;
    assign locked      = locked_r;
    assign err         = err_r;

    // Select value of the slot being held and of the slot expected next.
    always_comb begin
        cur_seg_s = 8'h00;
        nxt_seg_s = 8'h00;
        case (state_r)
            SCAN: begin
                cur_seg_s = 8'h01 << idx_r;
                nxt_seg_s = (idx_r == 3'd5) ? 8'h00 : (8'h01 << idx_inc_s);
            end
            GAP: begin
                cur_seg_s = 8'h00;
                nxt_seg_s = 8'h80;
            end
            NUMS: begin
                cur_seg_s = 8'h80;
                nxt_seg_s = 8'h01;
            end
            default: begin
                cur_seg_s = 8'h00;
                nxt_seg_s = 8'h00;
            end
        endcase
    end

    // Scan-order tracking, dwell checks, shadow fill and frame publication.
    always_comb begin
        state_s       = state_r;
        idx_s         = idx_r;
        code_s        = code_r;
        dwell_s       = dwell_r;
        shadow_s      = shadow_r;
        hour_s        = hour_r;
        minute_s      = minute_r;
        second_s      = second_r;
        num_s         = num_r;
        frame_valid_s = 1'b0;
        locked_s      = locked_r;
        err_s         = 1'b0;
        viol_s        = 1'b0;

        case (state_r)
            SYNC: begin
                if (relock_ok_s) begin
                    state_s        = SCAN;
                    idx_s          = 3'd0;
                    code_s         = codeout[6:0];
                    dwell_s        = DW'(1);
                    shadow_s[3:0]  = dig_s;
                    locked_s       = 1'b1;
                end else begin
                    locked_s       = 1'b0;
                end
            end
            SCAN, GAP, NUMS: begin
                if (seg == cur_seg_s) begin
                    if (dwell_r == DW'(MAX_DWELL)) begin
                        viol_s = 1'b1;
                    end else if ((state_r != GAP) && (codeout[6:0] != code_r)) begin
                        viol_s = 1'b1;
                    end else begin
                        dwell_s = dwell_r + DW'(1);
                    end
                end else if (seg == nxt_seg_s) begin
                    dwell_s = DW'(1);
                    code_s  = codeout[6:0];
                    if (state_r == GAP) begin
                        if (!dig_valid_s || (dig_s > 4'd3)) begin
                            viol_s = 1'b1;
                        end else begin
                            // Frame-complete edge: the whole shadow goes out at once.
                            state_s       = NUMS;
                            hour_s        = shadow_r[23:16];
                            minute_s      = shadow_r[15:8];
                            second_s      = shadow_r[7:0];
                            num_s         = dig_s[1:0];
                            frame_valid_s = 1'b1;
                        end
                    end else if (state_r == NUMS) begin
                        if (!dig_valid_s) begin
                            viol_s = 1'b1;
                        end else begin
                            state_s       = SCAN;
                            idx_s         = 3'd0;
                            shadow_s[3:0] = dig_s;
                        end
                    end else if (idx_r == 3'd5) begin
                        state_s = GAP;
                    end else if (!dig_valid_s) begin
                        viol_s = 1'b1;
                    end else begin
                        idx_s                   = idx_inc_s;
                        shadow_s[nib_lsb_s +: 4] = dig_s;
                    end
                end else begin
                    viol_s = 1'b1;
                end
            end
            default: begin
                state_s  = SYNC;
                locked_s = 1'b0;
            end
        endcase

        // A violation drops the partial frame; a valid first slot re-locks on the same edge.
        if (viol_s) begin
            err_s    = 1'b1;
            shadow_s = 24'h000000;
            dwell_s  = DW'(1);
            if (relock_ok_s) begin
                state_s       = SCAN;
                idx_s         = 3'd0;
                code_s        = codeout[6:0];
                shadow_s[3:0] = dig_s;
                locked_s      = 1'b1;
            end else begin
                state_s  = SYNC;
                idx_s    = 3'd0;
                locked_s = 1'b0;
            end
        end else begin
            err_s = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CP) begin
        if (CR) begin
            state_r       <= SYNC;
            idx_r         <= 3'd0;
            code_r        <= 7'h00;
            dwell_r       <= '0;
            shadow_r      <= 24'h000000;
            hour_r        <= 8'h00;
            minute_r      <= 8'h00;
            second_r      <= 8'h00;
            num_r         <= 2'd0;
            frame_valid_r <= 1'b0;
            locked_r      <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            state_r       <= state_s;
            idx_r         <= idx_s;
            code_r        <= code_s;
            dwell_r       <= dwell_s;
            shadow_r      <= shadow_s;
            hour_r        <= hour_s;
            minute_r      <= minute_s;
            second_r      <= second_s;
            num_r         <= num_s;
            frame_valid_r <= frame_valid_s;
            locked_r      <= locked_s;
            err_r         <= err_s;
        end
    end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: directed vector table, hand-written dwell/reset sequences,
// then randomized scan frames with injected faults compared against a behavioural model.
module tb_seg_scan_capture;

    localparam int MAXD = 16;

    logic       CP = 1'b0;
    logic       CR = 1'b1;
    logic [7:0] seg = 8'h00;
    logic [7:0] codeout = 8'h00;
    logic [7:0] hour, minute, second;
    logic [1:0] NUM;
    logic       frame_valid, locked, err;

    seg_scan_capture #(.MAX_DWELL(MAXD)) dut (
        .CP(CP), .CR(CR), .seg(seg), .codeout(codeout),
        .hour(hour), .minute(minute), .second(second), .NUM(NUM),
        .frame_valid(frame_valid), .locked(locked), .err(err)
    );

    always #5 CP = ~CP;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] ord [8]  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h00, 8'h80};
    logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Reference model: position in the slot order table (-1 = hunting), run length, digits.
    int         m_pos;
    int         m_run;
    logic [6:0] m_first;
    int         m_dig [6];
    logic [7:0] m_h, m_m, m_s;
    logic [1:0] m_n;
    logic       m_fv, m_lock, m_err;

    function automatic int dec7(input logic [6:0] c);
        for (int i = 0; i < 10; i++) begin
            if (pat[i] == c) return i;
        end
        return -1;
    endfunction

    task automatic model_step(input logic cr, input logic [7:0] s, input logic [7:0] c);
        int d;
        int np;
        logic bad;
        d     = dec7(c[6:0]);
        m_err = 1'b0;
        m_fv  = 1'b0;
        bad   = 1'b0;
        if (cr) begin
            m_pos = -1; m_lock = 1'b0;
            m_h = 8'h00; m_m = 8'h00; m_s = 8'h00; m_n = 2'd0;
        end else if (m_pos < 0) begin
            if (s == 8'h01 && d >= 0) begin
                m_pos = 0; m_run = 1; m_first = c[6:0]; m_dig[0] = d; m_lock = 1'b1;
            end
        end else begin
            np = (m_pos + 1) % 8;
            if (s == ord[m_pos]) begin
                m_run++;
                if (m_run > MAXD) bad = 1'b1;
                else if (s != 8'h00 && c[6:0] != m_first) bad = 1'b1;
            end else if (s == ord[np]) begin
                if (s != 8'h00 && d < 0) bad = 1'b1;
                else if (np == 7 && d > 3) bad = 1'b1;
                else begin
                    m_pos = np; m_run = 1; m_first = c[6:0];
                    if (np < 6) m_dig[np] = d;
                    if (np == 7) begin
                        m_h  = 8'((m_dig[5] << 4) + m_dig[4]);
                        m_m  = 8'((m_dig[3] << 4) + m_dig[2]);
                        m_s  = 8'((m_dig[1] << 4) + m_dig[0]);
                        m_n  = 2'(d);
                        m_fv = 1'b1;
                    end
                end
            end else begin
                bad = 1'b1;
            end
            if (bad) begin
                m_err = 1'b1;
                if (s == 8'h01 && d >= 0) begin
                    m_pos = 0; m_run = 1; m_first = c[6:0]; m_dig[0] = d; m_lock = 1'b1;
                end else begin
                    m_pos = -1; m_lock = 1'b0;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [28:0] exp);
        logic [28:0] got;
        got = {hour, minute, second, NUM, frame_valid, locked, err};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got h=%h m=%h s=%h num=%0d fv=%b lk=%b err=%b, expected h=%h m=%h s=%h num=%0d fv=%b lk=%b err=%b",
                     name, $time, got[28:21], got[20:13], got[12:5], got[4:3], got[2], got[1], got[0],
                     exp[28:21], exp[20:13], exp[12:5], exp[4:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic step(input logic cr, input logic [7:0] s, input logic [7:0] c);
        CR = cr; seg = s; codeout = c;
        @(posedge CP);
        model_step(cr, s, c);
        #1;
    endtask

    task automatic step_chk(input string name, input logic cr, input logic [7:0] s, input logic [7:0] c);
        step(cr, s, c);
        check(name, {m_h, m_m, m_s, m_n, m_fv, m_lock, m_err});
    endtask

    typedef struct {
        logic       cr;
        logic [7:0] s, c, eh, em, es;
        logic [1:0] en;
        logic       efv, elk, eer;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic cr, input logic [7:0] s, input logic [7:0] c,
                                input logic eer, input logic efv, input logic elk,
                                input logic [7:0] eh, input logic [7:0] em, input logic [7:0] es,
                                input logic [1:0] en);
        vec_t v;
        v.cr = cr; v.s = s; v.c = c; v.eh = eh; v.em = em; v.es = es;
        v.en = en; v.efv = efv; v.elk = elk; v.eer = eer;
        vq.push_back(v);
    endfunction

    int         dw;
    int         dg;
    logic [7:0] rs, rc;
    logic [28:0] f235958;
    logic [28:0] f120007;

    initial begin
        m_pos = -1; m_run = 0; m_first = 7'h00;
        m_h = 8'h00; m_m = 8'h00; m_s = 8'h00; m_n = 2'd0;
        m_fv = 1'b0; m_lock = 1'b0; m_err = 1'b0;
        for (int i = 0; i < 6; i++) m_dig[i] = 0;

        // Reset, loopback frame 23:59:58 NUM=2 with gap code noise and dp set.
        add(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 2'd0);
        add(1'b0, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 2'd0);
        add(1'b0, 8'h02, 8'h6D, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 2'd0);
        add(1'b0, 8'h04, 8'h6F, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 2'd0);
        add(1'b0, 8'h08, 8'h6D, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 2'd0);
        add(1'b0, 8'h10, 8'h4F, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 2'd0);
        add(1'b0, 8'h20, 8'h5B, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 2'd0);
        add(1'b0, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 2'd0);
        add(1'b0, 8'h80, 8'h5B, 1'b0, 1'b1, 1'b1, 8'h23, 8'h59, 8'h58, 2'd2);
        // Blank code on slot 0x04: err, unlock, hold the old frame, then relock silently.
        add(1'b0, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h23, 8'h59, 8'h58, 2'd2);
        add(1'b0, 8'h02, 8'h6D, 1'b0, 1'b0, 1'b1, 8'h23, 8'h59, 8'h58, 2'd2);
        add(1'b0, 8'h04, 8'h00, 1'b1, 1'b0, 1'b0, 8'h23, 8'h59, 8'h58, 2'd2);
        add(1'b0, 8'h08, 8'h6D, 1'b0, 1'b0, 1'b0, 8'h23, 8'h59, 8'h58, 2'd2);
        add(1'b0, 8'h01, 8'h07, 1'b0, 1'b0, 1'b1, 8'h23, 8'h59, 8'h58, 2'd2);
        add(1'b0, 8'h02, 8'h3F, 1'b0, 1'b0, 1'b1, 8'h23, 8'h59, 8'h58, 2'd2);
        add(1'b0, 8'h04, 8'h3F, 1'b0, 1'b0, 1'b1, 8'h23, 8'h59, 8'h58, 2'd2);
        add(1'b0, 8'h08, 8'h3F, 1'b0, 1'b0, 1'b1, 8'h23, 8'h59, 8'h58, 2'd2);
        add(1'b0, 8'h10, 8'h5B, 1'b0, 1'b0, 1'b1, 8'h23, 8'h59, 8'h58, 2'd2);
        add(1'b0, 8'h20, 8'h06, 1'b0, 1'b0, 1'b1, 8'h23, 8'h59, 8'h58, 2'd2);
        add(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h23, 8'h59, 8'h58, 2'd2);
        add(1'b0, 8'h80, 8'h06, 1'b0, 1'b1, 1'b1, 8'h12, 8'h00, 8'h07, 2'd1);
        // NUM slot showing 5: err and no frame_valid.
        add(1'b0, 8'h01, 8'h3F, 1'b0, 1'b0, 1'b1, 8'h12, 8'h00, 8'h07, 2'd1);
        add(1'b0, 8'h02, 8'h3F, 1'b0, 1'b0, 1'b1, 8'h12, 8'h00, 8'h07, 2'd1);
        add(1'b0, 8'h04, 8'h3F, 1'b0, 1'b0, 1'b1, 8'h12, 8'h00, 8'h07, 2'd1);
        add(1'b0, 8'h08, 8'h3F, 1'b0, 1'b0, 1'b1, 8'h12, 8'h00, 8'h07, 2'd1);
        add(1'b0, 8'h10, 8'h3F, 1'b0, 1'b0, 1'b1, 8'h12, 8'h00, 8'h07, 2'd1);
        add(1'b0, 8'h20, 8'h3F, 1'b0, 1'b0, 1'b1, 8'h12, 8'h00, 8'h07, 2'd1);
        add(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h12, 8'h00, 8'h07, 2'd1);
        add(1'b0, 8'h80, 8'h6D, 1'b1, 1'b0, 1'b0, 8'h12, 8'h00, 8'h07, 2'd1);
        // Non-one-hot select.
        add(1'b0, 8'h01, 8'h3F, 1'b0, 1'b0, 1'b1, 8'h12, 8'h00, 8'h07, 2'd1);
        add(1'b0, 8'h03, 8'h3F, 1'b1, 1'b0, 1'b0, 8'h12, 8'h00, 8'h07, 2'd1);
        add(1'b0, 8'h01, 8'hBF, 1'b0, 1'b0, 1'b1, 8'h12, 8'h00, 8'h07, 2'd1);

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].cr, vq[i].s, vq[i].c);
            check($sformatf("vec%0d", i),
                  {vq[i].eh, vq[i].em, vq[i].es, vq[i].en, vq[i].efv, vq[i].elk, vq[i].eer});
        end

        f120007 = {8'h12, 8'h00, 8'h07, 2'd1, 1'b0, 1'b1, 1'b0};
        f235958 = {8'h23, 8'h59, 8'h58, 2'd2, 1'b1, 1'b1, 1'b0};

        // Dwell limit: exactly MAXD cycles on one slot is fine.
        for (int i = 0; i < MAXD; i++) step_chk("dwell_ok", 1'b0, 8'h02, 8'h3F);
        check("dwell16", f120007);
        step_chk("after_dwell", 1'b0, 8'h04, 8'h3F);
        check("after_dwell_k", f120007);
        // Out-of-order 0x01 with a valid code: err and same-edge relock.
        step_chk("relock", 1'b0, 8'h01, 8'h3F);
        check("relock_k", {8'h12, 8'h00, 8'h07, 2'd1, 1'b0, 1'b1, 1'b1});
        // One cycle past the dwell limit.
        for (int i = 0; i < MAXD; i++) step_chk("dwell_run", 1'b0, 8'h02, 8'h3F);
        step_chk("dwell17", 1'b0, 8'h02, 8'h3F);
        check("dwell17_k", {8'h12, 8'h00, 8'h07, 2'd1, 1'b0, 1'b0, 1'b1});

        // Reset mid-frame, then a full frame is needed before the next publication.
        step_chk("cr_pre", 1'b0, 8'h01, 8'h7F);
        step_chk("cr_pre", 1'b0, 8'h02, 8'h6D);
        step_chk("cr_pre", 1'b0, 8'h04, 8'h6F);
        step_chk("cr_pre", 1'b0, 8'h08, 8'h6D);
        step(1'b1, 8'h10, 8'h4F);
        check("cr_mid", 29'h0);
        step_chk("cr_tail", 1'b0, 8'h20, 8'h5B);
        step_chk("cr_tail", 1'b0, 8'h00, 8'h00);
        step_chk("cr_tail", 1'b0, 8'h80, 8'h5B);
        check("cr_nofv", 29'h0);
        for (int k = 0; k < 7; k++) begin
            dg = (k == 0) ? 8 : (k == 1) ? 5 : (k == 2) ? 9 : (k == 3) ? 5 :
                 (k == 4) ? 3 : (k == 5) ? 2 : 0;
            rc = {1'b0, pat[dg]};
            step_chk("cr_frame", 1'b0, ord[k], rc);
        end
        step_chk("cr_frame", 1'b0, 8'h80, 8'h5B);
        check("cr_frame_k", f235958);

        // Randomized frames with occasional faults, long dwells and resets.
        for (int f = 0; f < 250; f++) begin
            for (int k = 0; k < 8; k++) begin
                dw = $urandom_range(1, 3);
                if ($urandom_range(0, 39) == 0) dw = $urandom_range(MAXD - 2, MAXD + 2);
                dg = (k == 7) ? $urandom_range(0, 3) : $urandom_range(0, 9);
                rs = ord[k];
                rc = {1'b0, pat[dg]};
                if (k == 6) rc = 8'($urandom);
                if (k == 7 && $urandom_range(0, 39) == 0) rc = {1'b0, pat[$urandom_range(4, 9)]};
                if ($urandom_range(0, 29) == 0) begin
                    if ($urandom_range(0, 1) == 1) rc = 8'($urandom);
                    else rs = 8'($urandom);
                end
                for (int r = 0; r < dw; r++) begin
                    step_chk("rand", ($urandom_range(0, 299) == 0), rs, {1'($urandom), rc[6:0]});
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
